// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet/IPv4 transmit constants and header state enum
//
// Purpose: constants used by the Ethernet, IPv4 and later UDP/ICMP transmit
// stages, plus the IPv4 header serialiser state encoding.
// Ports: none (package).

package eth_pkg;

   localparam logic [15:0] ETH_IP_TYPE     = 16'h0800;
   localparam logic [15:0] ETH_ARP_TYPE    = 16'h0806;
   localparam logic [7:0]  IPV4_VER_IHL    = 8'h45;
   localparam logic [15:0] IPV4_FLAGS_FRAG = 16'h4000;
   localparam logic [15:0] IPV4_HDR_LEN    = 16'd20;

   // One state per group of four header bytes.
   typedef enum logic [2:0] {
      WAIT_START,
      VER_LEN_TX,
      ID_FLAGS_TX,
      TTL_PROTO_CSUM_TX,
      SRC_TX,
      DST_TX
   } ipv4_hdr_state_t;

endpackage

// File: rtl/ipv4_csum_acc.sv
// rtl/ipv4_csum_acc.sv - ones-complement checksum accumulator (16-bit words)
//
// Purpose: sums 16-bit words into a 20-bit accumulator and presents the
// folded, inverted Internet checksum combinationally. Shared by IPv4, UDP
// and ICMP transmit stages.
// Ports:
//   aclk, aresetn  clock, synchronous active-low reset
//   clear          zero the accumulator (takes priority over add)
//   add            add word to the accumulator at this edge
//   word           16-bit word to add
//   csum           ~(fold(fold(acc))) of the current accumulator

import eth_pkg::*;

module ipv4_csum_acc (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        clear,
   input  logic        add,
   input  logic [15:0] word,
   output logic [15:0] csum
);

   logic [19:0] acc;
   logic [16:0] fold1;
   logic [16:0] fold2;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         acc <= 20'h0;
      end else if (clear) begin
         acc <= 20'h0;
      end else if (add) begin
         acc <= acc + {4'h0, word};
      end
   end

   // Two end-around folds: the first can itself carry out once more.
   always_comb begin
      fold1 = {1'b0, acc[15:0]} + {13'h0, acc[19:16]};
      fold2 = {1'b0, fold1[15:0]} + {16'h0, fold1[16]};
      csum  = ~fold2[15:0];
   end

endmodule

// File: rtl/ipv4_header_tx.sv
// rtl/ipv4_header_tx.sv - IPv4 header serialiser, one byte per clock
//
// Purpose: emits the 20-byte IPv4 header directly after the Ethernet header,
// starting the cycle after eth_header_ip_tx_done, computing the header
// checksum on the fly, and pulses ip_header_tx_done with the last byte.
// Optional feature macro: IPV4_ID_INCREMENT_EN (identification field
// increments after every header; otherwise it is constant zero).
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   ip_s_addr, ip_d_addr   source / destination address (latched at start)
//   ip_payload_len         payload length; total_len = len + 20 (wraps)
//   ip_protocol            protocol field
//   eth_header_ip_tx_done  start pulse, ignored unless idle
//   data_out               header byte stream (holds last byte when idle)
//   ip_header_tx_done      one-cycle pulse with header byte 19

import eth_pkg::*;

module ipv4_header_tx #(
   parameter logic [7:0] IP_TTL = 8'd64
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [31:0] ip_s_addr,
   input  logic [31:0] ip_d_addr,
   input  logic [15:0] ip_payload_len,
   input  logic [7:0]  ip_protocol,
   input  logic        eth_header_ip_tx_done,
   output logic [7:0]  data_out,
   output logic        ip_header_tx_done
);

   ipv4_hdr_state_t state, state_n;
   logic [1:0]  count, count_n;
   logic [7:0]  data_n;
   logic        done_n;

   logic [31:0] src_q;
   logic [31:0] dst_q;
   logic [7:0]  proto_q;
   logic [15:0] total_q;
   logic [7:0]  csum_lo_q;
   logic [15:0] id;

   logic        latch;
   logic        acc_clr;
   logic        acc_add;
   logic [15:0] acc_word;
   logic        csum_ld;
   logic [15:0] csum;

   ipv4_csum_acc u_csum (
      .aclk    (aclk),
      .aresetn (aresetn),
      .clear   (acc_clr),
      .add     (acc_add),
      .word    (acc_word),
      .csum    (csum)
   );

`ifdef IPV4_ID_INCREMENT_EN
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         id <= 16'h0000;
      end else if (done_n) begin
         id <= id + 16'd1;
      end
   end
`else
   assign id = 16'h0000;
`endif

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state             <= WAIT_START;
         count             <= 2'd0;
         data_out          <= 8'h00;
         ip_header_tx_done <= 1'b0;
      end else begin
         state             <= state_n;
         count             <= count_n;
         data_out          <= data_n;
         ip_header_tx_done <= done_n;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         src_q     <= 32'h0;
         dst_q     <= 32'h0;
         proto_q   <= 8'h0;
         total_q   <= 16'h0;
         csum_lo_q <= 8'h0;
      end else begin
         if (latch) begin
            src_q   <= ip_s_addr;
            dst_q   <= ip_d_addr;
            proto_q <= ip_protocol;
            total_q <= ip_payload_len + IPV4_HDR_LEN;
         end
         if (csum_ld) begin
            csum_lo_q <= csum[7:0];
         end
      end
   end

   // Within each state, {state, count} names the byte registered at the
   // coming edge; the accumulator word added at that edge rides alongside
   // so the sum is complete exactly when byte 10 needs it.
   always_comb begin
      state_n  = state;
      count_n  = count + 2'd1;
      data_n   = data_out;
      done_n   = 1'b0;
      latch    = 1'b0;
      acc_clr  = 1'b0;
      acc_add  = 1'b0;
      acc_word = 16'h0000;
      csum_ld  = 1'b0;

      case (state)
         WAIT_START: begin
            count_n = count;
            if (eth_header_ip_tx_done) begin
               state_n = VER_LEN_TX;
               count_n = 2'd1;
               data_n  = IPV4_VER_IHL;
               latch   = 1'b1;
               acc_clr = 1'b1;
            end
         end
         VER_LEN_TX: begin
            acc_add = 1'b1;
            case (count)
               2'd1: begin
                  data_n   = 8'h00;
                  acc_word = {IPV4_VER_IHL, 8'h00};
               end
               2'd2: begin
                  data_n   = total_q[15:8];
                  acc_word = total_q;
               end
               2'd3: begin
                  data_n   = total_q[7:0];
                  acc_word = id;
                  state_n  = ID_FLAGS_TX;
               end
               default: acc_add = 1'b0;
            endcase
         end
         ID_FLAGS_TX: begin
            acc_add = 1'b1;
            case (count)
               2'd0: begin
                  data_n   = id[15:8];
                  acc_word = IPV4_FLAGS_FRAG;
               end
               2'd1: begin
                  data_n   = id[7:0];
                  acc_word = {IP_TTL, proto_q};
               end
               2'd2: begin
                  data_n   = IPV4_FLAGS_FRAG[15:8];
                  acc_word = src_q[31:16];
               end
               default: begin
                  data_n   = IPV4_FLAGS_FRAG[7:0];
                  acc_word = src_q[15:0];
                  state_n  = TTL_PROTO_CSUM_TX;
               end
            endcase
         end
         TTL_PROTO_CSUM_TX: begin
            case (count)
               2'd0: begin
                  data_n   = IP_TTL;
                  acc_add  = 1'b1;
                  acc_word = dst_q[31:16];
               end
               2'd1: begin
                  data_n   = proto_q;
                  acc_add  = 1'b1;
                  acc_word = dst_q[15:0];
               end
               2'd2: begin
                  data_n  = csum[15:8];
                  csum_ld = 1'b1;
               end
               default: begin
                  data_n  = csum_lo_q;
                  state_n = SRC_TX;
               end
            endcase
         end
         SRC_TX: begin
            case (count)
               2'd0:    data_n = src_q[31:24];
               2'd1:    data_n = src_q[23:16];
               2'd2:    data_n = src_q[15:8];
               default: begin
                  data_n  = src_q[7:0];
                  state_n = DST_TX;
               end
            endcase
         end
         DST_TX: begin
            case (count)
               2'd0:    data_n = dst_q[31:24];
               2'd1:    data_n = dst_q[23:16];
               2'd2:    data_n = dst_q[15:8];
               default: begin
                  data_n  = dst_q[7:0];
                  done_n  = 1'b1;
                  state_n = WAIT_START;
               end
            endcase
         end
         default: begin
            state_n = WAIT_START;
            count_n = 2'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_ipv4_header_tx.sv
// tb/tb_ipv4_header_tx.sv - self-checking bench for ipv4_header_tx

module tb_ipv4_header_tx;

   logic        aclk;
   logic        aresetn;
   logic [31:0] ip_s_addr;
   logic [31:0] ip_d_addr;
   logic [15:0] ip_payload_len;
   logic [7:0]  ip_protocol;
   logic        eth_header_ip_tx_done;
   logic [7:0]  data_out;
   logic        ip_header_tx_done;

   int total;
   int bad;
   logic [15:0] mid;
   logic [7:0]  ref_b [0:19];

   ipv4_header_tx #(.IP_TTL(8'd64)) dut (
      .aclk                  (aclk),
      .aresetn               (aresetn),
      .ip_s_addr             (ip_s_addr),
      .ip_d_addr             (ip_d_addr),
      .ip_payload_len        (ip_payload_len),
      .ip_protocol           (ip_protocol),
      .eth_header_ip_tx_done (eth_header_ip_tx_done),
      .data_out              (data_out),
      .ip_header_tx_done     (ip_header_tx_done)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference header: fields laid out as bytes, checksum = ones-complement
   // of the ones-complement sum of the ten words with the checksum zeroed.
   function automatic void model(input logic [31:0] s, input logic [31:0] d,
                                 input logic [15:0] plen, input logic [7:0] p,
                                 input logic [15:0] id);
      int unsigned tl;
      int unsigned sum;
      logic [15:0] cs;
      tl = (int'(plen) + 20) % 65536;
      ref_b[0]  = 8'h45;          ref_b[1]  = 8'h00;
      ref_b[2]  = 8'(tl / 256);   ref_b[3]  = 8'(tl % 256);
      ref_b[4]  = id[15:8];       ref_b[5]  = id[7:0];
      ref_b[6]  = 8'h40;          ref_b[7]  = 8'h00;
      ref_b[8]  = 8'd64;          ref_b[9]  = p;
      ref_b[10] = 8'h00;          ref_b[11] = 8'h00;
      for (int i = 0; i < 4; i++) begin
         ref_b[12 + i] = 8'(s >> (24 - 8 * i));
         ref_b[16 + i] = 8'(d >> (24 - 8 * i));
      end
      sum = 0;
      for (int i = 0; i < 10; i++) sum += 256 * ref_b[2 * i] + ref_b[2 * i + 1];
      while (sum > 65535) sum = (sum % 65536) + (sum / 65536);
      cs = ~16'(sum);
      ref_b[10] = cs[15:8];
      ref_b[11] = cs[7:0];
   endfunction

   // Sends one header and checks every byte and the done pulse. disturb
   // changes inputs at byte 5 and pulses start at byte 7; abort asserts
   // reset while byte 10 is on the bus.
   task automatic header(input logic [31:0] s, input logic [31:0] d,
                         input logic [15:0] plen, input logic [7:0] p,
                         input bit disturb, input bit abort);
      model(s, d, plen, p, mid);
      ip_s_addr = s; ip_d_addr = d; ip_payload_len = plen; ip_protocol = p;
      eth_header_ip_tx_done = 1'b1;
      tick();
      eth_header_ip_tx_done = 1'b0;
      for (int k = 0; k < 20; k++) begin
         check($sformatf("byte%0d", k), 32'(data_out), 32'(ref_b[k]));
         check($sformatf("done@%0d", k), 32'(ip_header_tx_done), (k == 19) ? 32'd1 : 32'd0);
         if (disturb && k == 5) begin
            ip_s_addr = $urandom; ip_d_addr = $urandom;
            ip_payload_len = 16'($urandom); ip_protocol = 8'($urandom);
         end
         if (disturb && k == 7) eth_header_ip_tx_done = 1'b1;
         if (disturb && k == 8) eth_header_ip_tx_done = 1'b0;
         if (abort && k == 10) begin
            aresetn = 1'b0;
            tick();
            check("rst_data", 32'(data_out), 32'h0);
            check("rst_done", 32'(ip_header_tx_done), 32'h0);
            tick();
            aresetn = 1'b1;
            tick();
            mid = 16'h0000;
            return;
         end
         if (k < 19) tick();
      end
      tick();
      check("done_clear", 32'(ip_header_tx_done), 32'h0);
      check("hold_last", 32'(data_out), 32'(ref_b[19]));
`ifdef IPV4_ID_INCREMENT_EN
      mid = mid + 16'd1;
`endif
   endtask

   initial begin
      total = 0;
      bad = 0;
      mid = 16'h0000;
      aresetn = 1'b0;
      eth_header_ip_tx_done = 1'b0;
      ip_s_addr = 32'h0; ip_d_addr = 32'h0; ip_payload_len = 16'h0; ip_protocol = 8'h0;
      repeat (3) tick();
      aresetn = 1'b1;

      for (int i = 0; i < 50; i++) begin
         check("idle_data", 32'(data_out), 32'h0);
         check("idle_done", 32'(ip_header_tx_done), 32'h0);
         tick();
      end

      header(32'hC0A80001, 32'hC0A80002, 16'd28, 8'd17, 1'b0, 1'b0);
      header(32'hC0A80001, 32'hC0A80002, 16'd28, 8'd17, 1'b0, 1'b0);
      header(32'h0A000001, 32'h0A0000FE, 16'd100, 8'd17, 1'b1, 1'b0);
      repeat (4) tick();
      header(32'hC0A80001, 32'hC0A80002, 16'd28, 8'd17, 1'b0, 1'b1);
      header(32'hC0A80001, 32'hC0A80002, 16'd28, 8'd17, 1'b0, 1'b0);
      header(32'h11223344, 32'h55667788, 16'hFFF0, 8'd6, 1'b0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         header($urandom, $urandom, 16'($urandom_range(0, 1480)),
                8'($urandom), 1'b0, 1'b0);
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ipv4_header_tx.md
# ipv4_header_tx

Serialises the 20-byte IPv4 header, one byte per clock, directly after the Ethernet header of an IP frame. Starts on the `eth_header_ip_tx_done` pulse from `eth_header_tx` and emits its first byte on the very next cycle, so the byte stream stays gapless. Computes the header checksum on the fly while the header is being sent. Signals completion to the payload (UDP) stage with a single-cycle `ip_header_tx_done` pulse.

## Interface
- `IP_TTL`, default 8'd64: Time-to-Live value placed in header byte 8.
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, synchronous, active-low.
- `ip_s_addr`  in  32  source IPv4 address; byte 12 carries [31:24].
- `ip_d_addr`  in  32  destination IPv4 address.
- `ip_payload_len`  in  16  payload bytes following the IP header.
- `ip_protocol`  in  8  protocol field (17 = UDP).
- `eth_header_ip_tx_done`  in  1  start pulse, coincident with the last EtherType byte.
- `data_out`  out  8  header byte stream.
- `ip_header_tx_done`  out  1  pulse, coincident with the last header byte (byte 19).

## Operation
- Header bytes 0..19, in order:
  - 0x45, 0x00
  - total_len[15:8], total_len[7:0]
  - id[15:8], id[7:0]
  - 0x40, 0x00 (DF set)
  - IP_TTL, protocol
  - csum[15:8], csum[7:0]
  - src[31:0] MSB first
  - dst[31:0] MSB first
- `total_len = ip_payload_len + 20`, truncated to 16 bits. Upstream keeps the payload ≤1480; no saturation.
- States:
  - WAIT_START → VER_LEN_TX (bytes 0-3) → ID_FLAGS_TX (4-7) → TTL_PROTO_CSUM_TX (8-11) → SRC_TX (12-15) → DST_TX (16-19) → WAIT_START.
  - A 2-bit `count` indexes the byte within each state and wraps 3→0 on every state change.
- Start, in WAIT_START with `eth_header_ip_tx_done`=1:
  - latch `ip_s_addr`, `ip_d_addr`, `ip_protocol` and `total_len` into internal registers;
  - register `data_out` ← 0x45, set `count` ← 1, clear the accumulator.
  - All later bytes use the latched values only; input changes mid-header have no effect.
- Checksum, built from the latched values:
  - At each edge that registers bytes 1..9, add one 16-bit word to a 20-bit accumulator, in this order: 0x4500, total_len, id, 0x4000, {IP_TTL, protocol}, src_hi, src_lo, dst_hi, dst_lo.
  - At the edge that registers byte 10: fold end-around carry twice, invert, and store the result as `csum`.
- Start pulses outside WAIT_START are ignored. No queuing.
- `id` is a 16-bit register. Its update rule is set under Configuration.
- Reset at any point, including mid-header:
  - state WAIT_START, `count` 0, accumulator 0, `id` 0x0000;
  - `data_out` 0x00, `ip_header_tx_done` 0.

## Timing
- Latency: byte 0 appears on `data_out` in the cycle after the start pulse. Byte k appears k+1 cycles after the pulse.
- `ip_header_tx_done`:
  - high for exactly one cycle, together with byte 19 (20 cycles after the pulse);
  - registered at the same edge as byte 19;
  - cleared on the next edge.
- Back-to-back: a start pulse in the cycle right after the done pulse (state already WAIT_START) is accepted.
- `data_out` holds its last value while in WAIT_START.
- Reset values: `data_out` 0x00, `ip_header_tx_done` 0.

## Configuration
- `IPV4_ID_INCREMENT_EN` defined:
  - `id` increments by 1 at the edge that registers byte 19, wrapping 0xFFFF→0x0000;
  - the first frame after reset uses id 0x0000.
- Not defined: `id` is constant 0x0000 and no increment logic is built.

## Structure
- Shared package `eth_pkg`:
  - constants ETH_IP_TYPE, ETH_ARP_TYPE, IPV4_VER_IHL (8'h45), IPV4_FLAGS_FRAG (16'h4000), IPV4_HDR_LEN (16'd20);
  - the IPv4 header state enum.
- One sub-module, `ipv4_csum_acc`:
  - inputs: clear, add-enable, 16-bit word;
  - output: the folded, inverted 16-bit checksum;
  - reused later by the UDP and ICMP stages.

## Test plan
- Reset, then idle → `data_out`=0x00, done=0, no activity for 50 cycles.
- Single header: src C0A80001, dst C0A80002, payload 28, protocol 17, TTL 64.
  - Stream: 45 00 00 30 00 00 40 00 40 11 B9 69 C0 A8 00 01 C0 A8 00 02.
  - Done pulses with byte 02, 20 cycles after the start pulse.
- Back-to-back headers with the same fields:
  - with `IPV4_ID_INCREMENT_EN`: second header id 00 01, checksum B9 68;
  - without it: the second header is identical to the first.
- Inputs change at byte 5 mid-header, plus an extra start pulse at byte 7 → output is unaffected and exactly one done pulse is produced.
- `aresetn` low at byte 10 → outputs zero on the next cycle. A new start after release gives a correct full header with id 0x0000.
- Payload 0xFFF0 → total_len wraps to 0x0004. The checksum matches a reference computed with that wrapped value.
